// File: rtl/regf_pkg.sv
// Shared types for the integer register-file writeback path.
//   XLEN       - data width of one register
//   NREG       - number of architectural registers
//   reg_addr_t - register index
//   wb_entry_t - one pending register write {rd, data}
package regf_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   typedef logic [4:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t       rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regf_writeback_wb_fifo.sv
// Small synchronous FIFO of wb_entry_t holding long-latency results until
// the register-file write slot is free.
//   clk, rst     - clock, synchronous active-high reset
//   push, wr_ent - enqueue request and entry (ignored when full)
//   pop          - dequeue request (ignored when empty)
//   head         - entry at the front of the queue
//   full, empty  - occupancy flags
//   count        - number of stored entries
module wb_fifo
   import regf_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  wb_entry_t     wr_ent,
   input  logic          pop,
   output wb_entry_t     head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   wb_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_ent;
   end

endmodule

// File: rtl/regf_writeback.sv
// Writeback stage driving the single write port of the integer register file.
// ALU results own the write slot; long-latency results are queued and drain
// in order whenever the ALU leaves the slot free. A pending-write scoreboard
// lets issue logic stall on RAW/WAW hazards.
//   clk, rst                      - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data     - single-cycle ALU result (always accepted)
//   issue_valid/issue_rd          - long-latency op issued, marks rd pending
//   lu_valid/lu_ready/lu_rd/lu_data - long-latency result handshake
//   write_regf_en/addr_rd/rd_value - registered register-file write port
//   busy                          - pending-write bitmap
//   lq_count                      - result queue occupancy
//   err                           - sticky protocol-violation flag
module regf_writeback
   import regf_pkg::*;
#(
   parameter  int XLEN     = regf_pkg::XLEN,
   parameter  int NREG     = regf_pkg::NREG,
   parameter  int LQ_DEPTH = 2,
   localparam int CW       = $clog2(LQ_DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  reg_addr_t       alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            issue_valid,
   input  reg_addr_t       issue_rd,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  reg_addr_t       lu_rd,
   input  logic [XLEN-1:0] lu_data,
   output logic            write_regf_en,
   output reg_addr_t       addr_rd,
   output logic [XLEN-1:0] rd_value,
   output logic [NREG-1:0] busy,
   output logic [CW-1:0]   lq_count,
   output logic            err
);

   logic            alu_take;
   logic            lu_push;
   logic            lq_pop;
   logic            lq_full;
   logic            lq_empty;
   wb_entry_t       lq_head;
   wb_entry_t       lu_entry;

   logic            wen_nxt;
   reg_addr_t       addr_nxt;
   logic [XLEN-1:0] data_nxt;
   logic [NREG-1:0] busy_nxt;
   logic            err_nxt;

   // Writes to x0 are discarded, so such an ALU result leaves the slot free.
   assign alu_take = alu_valid && (alu_rd != '0);

   // Readiness looks only at current occupancy: a full queue refuses even
   // when it is draining this cycle, which keeps lu_ready off the pop path.
   assign lu_ready = !rst && !lq_full;
   assign lu_push  = lu_valid && lu_ready;
   assign lq_pop   = !alu_take && !lq_empty;
   assign lu_entry = '{rd: lu_rd, data: lu_data};

   wb_fifo #(
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk    (clk),
      .rst    (rst),
      .push   (lu_push),
      .wr_ent (lu_entry),
      .pop    (lq_pop),
      .head   (lq_head),
      .full   (lq_full),
      .empty  (lq_empty),
      .count  (lq_count)
   );

   always_comb begin
      wen_nxt  = 1'b0;
      addr_nxt = addr_rd;
      data_nxt = rd_value;
      busy_nxt = busy;
      err_nxt  = err;

      if (alu_take) begin
         wen_nxt  = 1'b1;
         addr_nxt = alu_rd;
         data_nxt = alu_data;
      end else if (lq_pop && (lq_head.rd != '0)) begin
         wen_nxt  = 1'b1;
         addr_nxt = lq_head.rd;
         data_nxt = lq_head.data;
         busy_nxt[lq_head.rd] = 1'b0;
      end

      // Set after clear so a same-cycle re-issue to the draining rd stays pending.
      if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;

      if ((issue_valid && (issue_rd != '0) && busy[issue_rd]) ||
          (alu_take && busy[alu_rd]) ||
          (lu_push && !busy[lu_rd]))
         err_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_regf_en <= 1'b0;
         addr_rd       <= '0;
         rd_value      <= '0;
         busy          <= '0;
         err           <= 1'b0;
      end else begin
         write_regf_en <= wen_nxt;
         addr_rd       <= addr_nxt;
         rd_value      <= data_nxt;
         busy          <= busy_nxt;
         err           <= err_nxt;
      end
   end

endmodule

// File: tb/tb_regf_writeback.sv
module tb_regf_writeback;
   import regf_pkg::*;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_rd = '0;
   logic [31:0] lu_data = '0;
   logic        write_regf_en;
   logic [4:0]  addr_rd;
   logic [31:0] rd_value;
   logic [31:0] busy;
   logic [1:0]  lq_count;
   logic        err;

   regf_writeback #(.XLEN(32), .NREG(32), .LQ_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .write_regf_en(write_regf_en), .addr_rd(addr_rd), .rd_value(rd_value),
      .busy(busy), .lq_count(lq_count), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   typedef struct { logic [4:0] rd; logic [31:0] data; int due; } exp_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

   exp_t        exq[$];   // expected register-file writes, in order
   ent_t        mq[$];    // reference content of the result queue
   logic [31:0] mbusy = '0;
   bit          merr  = 0;
   bit          last_acc;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every presented write must be the oldest expected one, on time.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (run) begin
            if (write_regf_en === 1'b1) begin
               if (exq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_write: got rd=%0d data=%0h expected none", addr_rd, rd_value);
               end else begin
                  e = exq.pop_front();
                  chk("wr_rd", 64'(addr_rd), 64'(e.rd));
                  chk("wr_data", 64'(rd_value), 64'(e.data));
                  chk("wr_cycle", 64'(cyc), 64'(e.due));
               end
            end else if (exq.size() > 0 && exq[0].due <= cyc) begin
               e = exq.pop_front();
               total++; bad++;
               $display("FAIL missing_write: got none expected rd=%0d data=%0h", e.rd, e.data);
            end
         end
      end
   end

   // Drive one cycle, check observable state against the model, then advance
   // the model by the rules of the coming clock edge.
   task automatic step(bit r, bit av, logic [4:0] ar, logic [31:0] ad,
                       bit iv, logic [4:0] ir,
                       bit lv, logic [4:0] lr, logic [31:0] ld);
      bit   acc, take;
      ent_t h;
      logic [31:0] nb;
      rst = r; alu_valid = av; alu_rd = ar; alu_data = ad;
      issue_valid = iv; issue_rd = ir;
      lu_valid = lv; lu_rd = lr; lu_data = ld;
      #1;
      chk("lu_ready", 64'(lu_ready), 64'(!r && mq.size() < D));
      chk("lq_count", 64'(lq_count), 64'(mq.size()));
      chk("busy", 64'(busy), 64'(mbusy));
      chk("err", 64'(err), 64'(merr));
      acc = 0;
      if (r) begin
         mq.delete();
         mbusy = '0;
         merr  = 0;
      end else begin
         acc  = lv && (mq.size() < D);
         take = av && (ar != 0);
         if ((iv && ir != 0 && mbusy[ir]) || (take && mbusy[ar]) || (acc && !mbusy[lr]))
            merr = 1;
         nb = mbusy;
         if (take) begin
            exq.push_back('{rd: ar, data: ad, due: cyc + 1});
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.rd != 0) begin
               exq.push_back('{rd: h.rd, data: h.data, due: cyc + 1});
               nb[h.rd] = 1'b0;
            end
         end
         if (iv && ir != 0) nb[ir] = 1'b1;
         nb[0] = 1'b0;
         mbusy = nb;
         if (acc) mq.push_back('{rd: lr, data: ld});
      end
      last_acc = acc;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [4:0] pick_free();
      logic [4:0] v;
      v = 5'($urandom_range(1, 31));
      for (int t = 0; t < 3 && mbusy[v]; t++) v = 5'($urandom_range(1, 31));
      return v;
   endfunction

   function automatic logic [4:0] pick_busy();
      logic [4:0] cand[$];
      for (int i = 1; i < 32; i++) if (mbusy[i]) cand.push_back(5'(i));
      if (cand.size() == 0 || $urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
      return cand[$urandom_range(0, cand.size() - 1)];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      repeat (3) @(posedge clk);
      @(negedge clk);
      run = 1;
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);              // reset values
      idle(1);

      // ALU only
      step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
      idle(2);

      // issue then result
      step(0, 0, 0, 0, 1, 7, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 1, 7, 32'hDEAD);
      idle(3);

      // ALU contention against a queued result
      step(0, 0, 0, 0, 1, 3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, 32'h3333);
      step(0, 1, 4, 32'h4444, 0, 0, 0, 0, 0);
      step(0, 1, 5, 32'h5555, 0, 0, 0, 0, 0);
      step(0, 1, 6, 32'h6666, 0, 0, 0, 0, 0);
      idle(3);

      // backpressure with the ALU holding the slot
      step(0, 0, 0, 0, 1, 8, 0, 0, 0);
      step(0, 0, 0, 0, 1, 9, 0, 0, 0);
      step(0, 0, 0, 0, 1, 10, 0, 0, 0);
      idx = 0;
      for (int k = 0; k < 20 && idx < 3; k++) begin
         step(0, k < 4, 5'(20 + k), 32'hA000 + k, 0, 0,
              1, 5'(8 + idx), 32'hB000 + idx);
         if (last_acc) idx++;
      end
      chk("bp_all_accepted", 64'(idx), 64'd3);
      idle(5);

      // x0 handling
      step(0, 1, 0, 32'hFFFF, 1, 0, 1, 0, 32'h0BAD);
      idle(3);

      // double issue, then reset with a non-empty queue
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 0, 0, 0);
      step(0, 1, 9, 32'h9, 0, 0, 1, 2, 32'h2222);
      step(0, 1, 11, 32'h11, 0, 0, 0, 0, 0);
      step(1, 1, 12, 32'h12, 0, 0, 0, 0, 0);
      idle(3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit          r, av, iv, lv;
         logic [4:0]  ar, ir, lr;
         r  = ($urandom_range(0, 299) == 0);
         av = ($urandom_range(0, 2) == 0);
         ar = ($urandom_range(0, 7) == 0) ? 5'd0 : pick_free();
         iv = ($urandom_range(0, 3) == 0);
         ir = ($urandom_range(0, 15) == 0) ? 5'd0 : pick_free();
         lv = ($urandom_range(0, 1) == 0);
         lr = pick_busy();
         step(r, av, ar, $urandom(), iv, ir, lv, lr, $urandom());
      end

      for (int k = 0; k < 20 && (mq.size() > 0 || exq.size() > 0); k++) idle(1);
      idle(2);
      chk("drain_queue", 64'(exq.size()), 64'd0);
      run = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
